// File: rtl/mix_word.sv
// AES MixColumns / InvMixColumns on a single 32-bit column, mode chosen per word.
// Latency: 1 cycle (registered output), one word per clock.
// Backpressure: none; a word is accepted on every cycle that in_valid is high.
module mix_word (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        inverse,
    input  logic [31:0] word,
    output logic        out_valid,
    output logic [31:0] mixed_word
);

    // GF(2^8) multiply by 2, reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    logic [7:0] a [4];
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] fwd [4];
    logic [7:0] inv [4];
    logic [31:0] result;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a[i]  = word[31-8*i -: 8];
            m2[i] = xtime(a[i]);
            m4[i] = xtime(m2[i]);
            m8[i] = xtime(m4[i]);
            m3[i] = m2[i] ^ a[i];
            m9[i] = m8[i] ^ a[i];
            mb[i] = m8[i] ^ m2[i] ^ a[i];
            md[i] = m8[i] ^ m4[i] ^ a[i];
            me[i] = m8[i] ^ m4[i] ^ m2[i];
        end

        fwd[0] = m2[0] ^ m3[1] ^ a[2]  ^ a[3];
        fwd[1] = a[0]  ^ m2[1] ^ m3[2] ^ a[3];
        fwd[2] = a[0]  ^ a[1]  ^ m2[2] ^ m3[3];
        fwd[3] = m3[0] ^ a[1]  ^ a[2]  ^ m2[3];

        inv[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
        inv[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
        inv[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
        inv[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];

        result = inverse ? {inv[0], inv[1], inv[2], inv[3]}
                         : {fwd[0], fwd[1], fwd[2], fwd[3]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            mixed_word <= 32'h0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                mixed_word <= result;
            end
        end
    end

endmodule

// File: tb/tb_mix_word.sv
// Directed and round-trip bench for mix_word.
module tb_mix_word;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        inverse;
    logic [31:0] word;
    logic        out_valid;
    logic [31:0] mixed_word;

    int n_checks;
    int n_errors;

    mix_word dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .inverse    (inverse),
        .word       (word),
        .out_valid  (out_valid),
        .mixed_word (mixed_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Shift-and-add GF(2^8) multiply, independent of any xtime chain.
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h00;
        s = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ s;
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] ref_mix(input logic [31:0] w, input logic inv);
        logic [7:0] coef [4];
        logic [7:0] a [4];
        logic [7:0] b [4];
        if (inv) begin
            coef[0] = 8'h0E; coef[1] = 8'h0B; coef[2] = 8'h0D; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++) a[c] = w[31-8*c -: 8];
        for (int r = 0; r < 4; r++) begin
            b[r] = 8'h00;
            for (int c = 0; c < 4; c++) b[r] = b[r] ^ gmul(a[c], coef[(c - r + 4) % 4]);
        end
        return {b[0], b[1], b[2], b[3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic v, input logic inv, input logic [31:0] w);
        in_valid = v;
        inverse  = inv;
        word     = w;
        tick();
    endtask

    logic [31:0] fwd_in  [6] = '{32'hdb135345, 32'hf20a225c, 32'hd4d4d4d5,
                                 32'h2d26314c, 32'h01010101, 32'hc6c6c6c6};
    logic [31:0] fwd_out [6] = '{32'h8e4da1bc, 32'h9fdc589d, 32'hd5d5d7d6,
                                 32'h4d7ebdf8, 32'h01010101, 32'hc6c6c6c6};
    logic [31:0] inv_in  [3] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h4d7ebdf8};
    logic [31:0] inv_out [3] = '{32'hdb135345, 32'hf20a225c, 32'h2d26314c};

    initial begin
        logic [31:0] w;
        logic [31:0] f;
        logic [31:0] held;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        in_valid = 1'b1;
        inverse  = 1'b0;
        word     = 32'hdb135345;

        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_valid", {31'b0, out_valid}, 32'h0);
            check("rst_data", mixed_word, 32'h0);
        end
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            apply(1'b1, 1'b0, fwd_in[i]);
            check($sformatf("fwd%0d_valid", i), {31'b0, out_valid}, 32'h1);
            check($sformatf("fwd%0d_data", i), mixed_word, fwd_out[i]);
        end

        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b1, inv_in[i]);
            check($sformatf("inv%0d_valid", i), {31'b0, out_valid}, 32'h1);
            check($sformatf("inv%0d_data", i), mixed_word, inv_out[i]);
        end

        for (int i = 0; i < 4; i++) begin
            apply(1'b1, i[0], 32'hf20a225c);
            check($sformatf("alt%0d_valid", i), {31'b0, out_valid}, 32'h1);
            check($sformatf("alt%0d_data", i), mixed_word,
                  i[0] ? ref_mix(32'hf20a225c, 1'b1) : 32'h9fdc589d);
        end
        held = ref_mix(32'hf20a225c, 1'b1);

        for (int i = 0; i < 3; i++) begin
            apply(1'b0, i[0], 32'h12345678 + i);
            check($sformatf("bubble%0d_valid", i), {31'b0, out_valid}, 32'h0);
            check($sformatf("bubble%0d_hold", i), mixed_word, held);
        end

        apply(1'b1, 1'b0, 32'h2d26314c);
        check("pre_rst_data", mixed_word, 32'h4d7ebdf8);
        rst = 1'b1;
        apply(1'b1, 1'b0, 32'hdb135345);
        check("mid_rst_valid", {31'b0, out_valid}, 32'h0);
        check("mid_rst_data", mixed_word, 32'h0);
        rst = 1'b0;
        apply(1'b1, 1'b0, 32'hdb135345);
        check("post_rst_data", mixed_word, 32'h8e4da1bc);

        for (int i = 0; i < 1000; i++) begin
            w = $urandom;
            apply(1'b1, 1'b0, w);
            f = mixed_word;
            check("rand_fwd", f, ref_mix(w, 1'b0));
            apply(1'b1, 1'b1, f);
            check("rand_trip", mixed_word, w);
        end

        in_valid = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mix_word.md
Name: mix_word

Overview:
- Single-column AES MixColumns transform on one 32-bit word (4 state bytes of one column), GF(2^8) with polynomial x^8+x^4+x^3+x+1 (0x11B).
- Supports forward MixColumns (encrypt round) and InvMixColumns (decrypt round), chosen per word.
- Output is registered: one-cycle latency, full throughput of one word per clock.
- Used as the per-column building block of the AES round datapath; four instances cover a full 128-bit state.

Parameters:
- None. The width is fixed at 32 bits, which is 4 bytes.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  word/inverse are sampled this cycle
- inverse  input  1  0 = MixColumns, 1 = InvMixColumns
- word  input  32  input column; word[31:24]=a0 (row 0), [23:16]=a1, [15:8]=a2, [7:0]=a3
- out_valid  output  1  mixed_word holds a new result
- mixed_word  output  32  output column, same byte ordering (b0 in [31:24])

Behaviour:
- Reset (rst=1 at a rising edge):
  - out_valid <= 0 and mixed_word <= 32'h0.
  - rst has priority over in_valid in the same cycle; the word presented that cycle is discarded.
- Normal operation:
  - On each rising edge with rst=0, out_valid <= in_valid.
  - When in_valid=1, mixed_word <= transform(word, inverse).
  - When in_valid=0, mixed_word holds its previous value.
- Latency and throughput:
  - Latency is exactly 1 cycle.
  - No backpressure: a new word is accepted every cycle, and back-to-back words with mixed inverse values are legal.
- xtime(x) = {x[6:0],1'b0} XOR (x[7] ? 8'h1B : 8'h00).
  - Multiplication by 3 = xtime(x)^x.
  - Multiplication by 9, 0B, 0D and 0E is built from repeated xtime plus XOR.
- Forward transform (inverse=0):
  - b0=2a0^3a1^a2^a3
  - b1=a0^2a1^3a2^a3
  - b2=a0^a1^2a2^3a3
  - b3=3a0^a1^a2^2a3
- Inverse transform (inverse=1):
  - b0=0E·a0^0B·a1^0D·a2^09·a3
  - b1=09·a0^0E·a1^0B·a2^0D·a3
  - b2=0D·a0^09·a1^0E·a2^0B·a3
  - b3=0B·a0^0D·a1^09·a2^0E·a3
- Arithmetic properties:
  - All arithmetic is carry-free XOR; there is no overflow case because every byte stays 8 bits.
  - Inverse(Forward(w)) = w for all 2^32 words.
  - Words with all four bytes equal map to themselves in both modes.
- X handling: inputs are ignored when in_valid=0. After reset, outputs must never carry X.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, word=32'hdb135345 -> out_valid=0, mixed_word=32'h0; the first valid output appears one cycle after the first non-reset accepted word.
- Forward known-answer vectors (inverse=0), one per cycle back-to-back; each result appears exactly 1 cycle later with out_valid=1:
  - db135345 -> 8e4da1bc
  - f20a225c -> 9fdc589d
  - d4d4d4d5 -> d5d5d7d6
  - 2d26314c -> 4d7ebdf8
  - 01010101 -> 01010101
  - c6c6c6c6 -> c6c6c6c6
- Inverse known-answer vectors (inverse=1):
  - 8e4da1bc -> db135345
  - 9fdc589d -> f20a225c
  - 4d7ebdf8 -> 2d26314c
- Interleaved modes: alternate inverse=0/1 every cycle on the same word 32'hf20a225c -> outputs alternate 9fdc589d / inverse result, with no pipeline mixing.
- Gaps and reset mid-stream:
  - Bubble: in_valid dropped for 3 cycles -> out_valid=0 and mixed_word holds its last value.
  - Mid-stream reset: assert rst while in_valid=1 -> the next cycle shows out_valid=0 and mixed_word=0.
- Randomized round trip: 1000 random words applied forward, with each result fed back with inverse=1 -> the original word is returned every time; cross-check against a reference model.
